// File: rtl/in_debouncer_pkg.sv
// ---------------------------------------------------------------------------
// in_debouncer_pkg
//   Shared types and defaults for the input debouncer slice.
//   - state_t      : 2-bit FSM encoding. Bit 1 is the accepted (clean)
//                    level, bit 0 marks a qualification in progress, so the
//                    outputs decode straight from the state flops.
//   - DB_CYCLES_DEF: default qualification length in synchronized cycles.
//   - CNT_W_DEF    : default stability counter width.
// ---------------------------------------------------------------------------
package in_debouncer_pkg;

  typedef enum logic [1:0] {
    LOW    = 2'd0,
    WAIT_H = 2'd1,
    HIGH   = 2'd2,
    WAIT_L = 2'd3
  } state_t;

  localparam int DB_CYCLES_DEF = 4;
  localparam int CNT_W_DEF     = 8;

  // Accepted level carried by a state: LOW/WAIT_H hold 0, HIGH/WAIT_L hold 1.
  function automatic logic state_level(input state_t s);
    return s[1];
  endfunction

  // True while a candidate level is being qualified.
  function automatic logic state_busy(input state_t s);
    return s[0];
  endfunction

endpackage

// File: rtl/in_debouncer_sync_2ff.sv
// ---------------------------------------------------------------------------
// sync_2ff
//   Two-flop synchronizer for a single asynchronous bit.
//   Ports:
//     Clk   - rising-edge clock
//     Reset - synchronous, active-high; clears both stages
//     d     - asynchronous input
//     q     - synchronized output (second stage)
// ---------------------------------------------------------------------------
module sync_2ff (
  input  logic Clk,
  input  logic Reset,
  input  logic d,
  output logic q
);

  logic r_s1;
  logic r_s2;

  // r_s1 may go metastable; only r_s2 is allowed to fan out.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_s1 <= 1'b0;
      r_s2 <= 1'b0;
    end else begin
      r_s1 <= d;
      r_s2 <= r_s1;
    end
  end

  assign q = r_s2;

endmodule

// File: rtl/in_debouncer.sv
// ---------------------------------------------------------------------------
// in_debouncer
//   Synchronizes and debounces a bouncy serial input bit before it feeds the
//   sequence-detector FSM. A new level is accepted only after the
//   synchronized input has differed from the current clean level for
//   DB_CYCLES consecutive clock edges; any reversal in between restarts
//   qualification from zero.
//   Parameters:
//     DB_CYCLES - qualification length, 1..255
//     CNT_W     - counter width, 2**CNT_W > DB_CYCLES
//   Ports:
//     Clk      - rising-edge system clock
//     Reset    - synchronous, active-high reset
//     raw_in   - asynchronous, bouncy input
//     in_clean - debounced, synchronized level
//     rise     - one-cycle pulse on the first cycle in_clean reads 1
//     fall     - one-cycle pulse on the first cycle in_clean reads 0
//     busy     - high while a candidate level change is being qualified
// ---------------------------------------------------------------------------
module in_debouncer
  import in_debouncer_pkg::*;
#(
  parameter int DB_CYCLES = DB_CYCLES_DEF,
  parameter int CNT_W     = CNT_W_DEF
) (
  input  logic Clk,
  input  logic Reset,
  input  logic raw_in,
  output logic in_clean,
  output logic rise,
  output logic fall,
  output logic busy
);

  // Elaboration-time parameter sanity checks.
  if (DB_CYCLES < 1 || DB_CYCLES > 255) begin : g_bad_db_cycles
    $error("in_debouncer: DB_CYCLES=%0d outside 1..255", DB_CYCLES);
  end
  if (CNT_W < 1 || CNT_W > 31 || (1 << CNT_W) <= DB_CYCLES) begin : g_bad_cnt_w
    $error("in_debouncer: CNT_W=%0d too narrow for DB_CYCLES=%0d", CNT_W, DB_CYCLES);
  end

  // Count value at which the next differing edge completes qualification.
  localparam logic [CNT_W-1:0] LP_LAST      = CNT_W'(DB_CYCLES - 1);
  // With a single-cycle window the stable states toggle directly and the
  // WAIT states are never entered.
  localparam bit               LP_IMMEDIATE = (DB_CYCLES == 1);

  logic             w_s2;
  logic             w_diff;
  logic             w_in_clean;
  logic             w_busy;

  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic             r_rise;
  logic             r_fall;

  state_t           w_nxt_state;
  logic [CNT_W-1:0] w_nxt_cnt;
  logic             w_nxt_rise;
  logic             w_nxt_fall;

  // -------------------------------------------------------------------------
  // Synchronizer: nothing below touches raw_in directly.
  // -------------------------------------------------------------------------
  sync_2ff u_sync (
    .Clk   (Clk),
    .Reset (Reset),
    .d     (raw_in),
    .q     (w_s2)
  );

  assign w_diff = w_s2 ^ w_in_clean;

  // -------------------------------------------------------------------------
  // State register (also holds counter and edge pulses).
  // -------------------------------------------------------------------------
  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_state <= LOW;
      r_cnt   <= '0;
      r_rise  <= 1'b0;
      r_fall  <= 1'b0;
    end else begin
      r_state <= w_nxt_state;
      r_cnt   <= w_nxt_cnt;
      r_rise  <= w_nxt_rise;
      r_fall  <= w_nxt_fall;
    end
  end

  // -------------------------------------------------------------------------
  // Next-state logic.
  // Entering a WAIT state already counts the first differing edge (cnt=1),
  // so the toggle lands on the DB_CYCLES-th consecutive differing edge.
  // The counter only advances while cnt < LP_LAST and is cleared on every
  // exit from a WAIT state, so it can neither exceed LP_LAST nor wrap.
  // -------------------------------------------------------------------------
  always_comb begin
    w_nxt_state = r_state;
    w_nxt_cnt   = r_cnt;
    w_nxt_rise  = 1'b0;
    w_nxt_fall  = 1'b0;

    unique case (r_state)
      LOW: begin
        w_nxt_cnt = '0;
        if (w_diff) begin
          if (LP_IMMEDIATE) begin
            w_nxt_state = HIGH;
            w_nxt_rise  = 1'b1;
          end else begin
            w_nxt_state = WAIT_H;
            w_nxt_cnt   = CNT_W'(1);
          end
        end
      end

      HIGH: begin
        w_nxt_cnt = '0;
        if (w_diff) begin
          if (LP_IMMEDIATE) begin
            w_nxt_state = LOW;
            w_nxt_fall  = 1'b1;
          end else begin
            w_nxt_state = WAIT_L;
            w_nxt_cnt   = CNT_W'(1);
          end
        end
      end

      WAIT_H: begin
        if (!w_diff) begin
          // Glitch: back to the old level, no credit kept, no pulse.
          w_nxt_state = LOW;
          w_nxt_cnt   = '0;
        end else if (r_cnt >= LP_LAST) begin
          w_nxt_state = HIGH;
          w_nxt_cnt   = '0;
          w_nxt_rise  = 1'b1;
        end else begin
          w_nxt_cnt   = r_cnt + CNT_W'(1);
        end
      end

      WAIT_L: begin
        if (!w_diff) begin
          w_nxt_state = HIGH;
          w_nxt_cnt   = '0;
        end else if (r_cnt >= LP_LAST) begin
          w_nxt_state = LOW;
          w_nxt_cnt   = '0;
          w_nxt_fall  = 1'b1;
        end else begin
          w_nxt_cnt   = r_cnt + CNT_W'(1);
        end
      end

      default: begin
        w_nxt_state = LOW;
        w_nxt_cnt   = '0;
      end
    endcase
  end

  // -------------------------------------------------------------------------
  // Output decode. The encoding puts the clean level in bit 1 and the
  // qualifying flag in bit 0, so both outputs come straight off flops and
  // reset to 0 together with the state.
  // -------------------------------------------------------------------------
  always_comb begin
    w_in_clean = state_level(r_state);
    w_busy     = state_busy(r_state);
  end

  assign in_clean = w_in_clean;
  assign busy     = w_busy;
  assign rise     = r_rise;
  assign fall     = r_fall;

endmodule

// File: tb/tb_in_debouncer.sv
module tb_in_debouncer;

  logic Clk;
  logic Reset, raw_in, in_clean, rise, fall, busy;      // DB_CYCLES = 4
  logic rst1, raw1, clean1, rise1, fall1, busy1;        // DB_CYCLES = 1

  int checks = 0;
  int errors = 0;

  in_debouncer #(.DB_CYCLES(4), .CNT_W(8)) u_dut4 (
    .Clk(Clk), .Reset(Reset), .raw_in(raw_in),
    .in_clean(in_clean), .rise(rise), .fall(fall), .busy(busy)
  );

  in_debouncer #(.DB_CYCLES(1), .CNT_W(2)) u_dut1 (
    .Clk(Clk), .Reset(rst1), .raw_in(raw1),
    .in_clean(clean1), .rise(rise1), .fall(fall1), .busy(busy1)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation still running at %0t, required finish earlier", $time);
    $fatal(1, "watchdog expired");
  end

  // One rising edge, then sample 1 time unit later.
  task automatic tick;
    @(posedge Clk);
    #1;
  endtask

  task automatic test_reset;
    Reset = 1'b1; rst1 = 1'b1; raw_in = 1'b1; raw1 = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if ({in_clean, rise, fall, busy} !== 4'b0000) begin
        errors++;
        $display("FAIL reset_db4 cyc%0d: got clean/rise/fall/busy=%b, expected 0000", i,
                 {in_clean, rise, fall, busy});
      end
      checks++;
      if ({clean1, rise1, fall1, busy1} !== 4'b0000) begin
        errors++;
        $display("FAIL reset_db1 cyc%0d: got clean/rise/fall/busy=%b, expected 0000", i,
                 {clean1, rise1, fall1, busy1});
      end
    end
    raw_in = 1'b0; raw1 = 1'b0; Reset = 1'b0; rst1 = 1'b0;
    repeat (4) tick();
    checks++;
    if ({in_clean, rise, fall, busy} !== 4'b0000) begin
      errors++;
      $display("FAIL reset_idle: got clean/rise/fall/busy=%b, expected 0000",
               {in_clean, rise, fall, busy});
    end
  endtask

  // From LOW, raw_in goes high and stays: sample point j is after edge k+j.
  task automatic test_clean_rise;
    logic e_clean, e_rise, e_busy;
    raw_in = 1'b1;
    for (int j = 0; j <= 7; j++) begin
      tick();
      e_busy  = (j >= 2 && j <= 4);
      e_clean = (j >= 5);
      e_rise  = (j == 5);
      checks++;
      if ({in_clean, rise, fall, busy} !== {e_clean, e_rise, 1'b0, e_busy}) begin
        errors++;
        $display("FAIL clean_rise k+%0d: got clean/rise/fall/busy=%b, expected %b", j,
                 {in_clean, rise, fall, busy}, {e_clean, e_rise, 1'b0, e_busy});
      end
    end
  endtask

  // From HIGH, raw_in goes low and stays.
  task automatic test_clean_fall;
    logic e_clean, e_fall, e_busy;
    raw_in = 1'b0;
    for (int j = 0; j <= 7; j++) begin
      tick();
      e_busy  = (j >= 2 && j <= 4);
      e_clean = (j < 5);
      e_fall  = (j == 5);
      checks++;
      if ({in_clean, rise, fall, busy} !== {e_clean, 1'b0, e_fall, e_busy}) begin
        errors++;
        $display("FAIL clean_fall k+%0d: got clean/rise/fall/busy=%b, expected %b", j,
                 {in_clean, rise, fall, busy}, {e_clean, 1'b0, e_fall, e_busy});
      end
    end
  endtask

  // From LOW, raw_in high for 2 sampling edges then low again.
  task automatic test_glitch;
    logic e_busy;
    for (int j = 0; j <= 7; j++) begin
      raw_in = (j < 2);
      tick();
      e_busy = (j == 2 || j == 3);
      checks++;
      if ({in_clean, rise, fall, busy} !== {1'b0, 1'b0, 1'b0, e_busy}) begin
        errors++;
        $display("FAIL glitch k+%0d: got clean/rise/fall/busy=%b, expected %b", j,
                 {in_clean, rise, fall, busy}, {1'b0, 1'b0, 1'b0, e_busy});
      end
    end
  endtask

  // Reset pulsed at edge k+3 while qualifying a high level; raw_in held high.
  task automatic test_reset_mid_qual;
    logic e_clean, e_rise, e_busy;
    raw_in = 1'b1;
    repeat (3) tick();                     // edges k, k+1, k+2
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL reset_mid_pre: got busy=%b, expected 1", busy);
    end
    Reset = 1'b1;
    tick();                                // edge k+3
    Reset = 1'b0;
    checks++;
    if ({in_clean, rise, fall, busy} !== 4'b0000) begin
      errors++;
      $display("FAIL reset_mid_in: got clean/rise/fall/busy=%b, expected 0000",
               {in_clean, rise, fall, busy});
    end
    // Edge k+4 is the first post-release sampling edge (j=0).
    for (int j = 0; j <= 7; j++) begin
      tick();
      e_busy  = (j >= 2 && j <= 4);
      e_clean = (j >= 5);
      e_rise  = (j == 5);
      checks++;
      if ({in_clean, rise, fall, busy} !== {e_clean, e_rise, 1'b0, e_busy}) begin
        errors++;
        $display("FAIL reset_mid_post k+%0d: got clean/rise/fall/busy=%b, expected %b", j + 4,
                 {in_clean, rise, fall, busy}, {e_clean, e_rise, 1'b0, e_busy});
      end
    end
  endtask

  // Reset while HIGH: clean drops without a fall pulse, then a full requalify.
  task automatic test_reset_in_high;
    logic e_clean, e_rise, e_busy;
    checks++;
    if (in_clean !== 1'b1) begin
      errors++;
      $display("FAIL reset_high_pre: got in_clean=%b, expected 1", in_clean);
    end
    Reset = 1'b1;
    tick();
    Reset = 1'b0;
    checks++;
    if ({in_clean, rise, fall, busy} !== 4'b0000) begin
      errors++;
      $display("FAIL reset_high_in: got clean/rise/fall/busy=%b, expected 0000",
               {in_clean, rise, fall, busy});
    end
    for (int j = 0; j <= 7; j++) begin
      tick();
      e_busy  = (j >= 2 && j <= 4);
      e_clean = (j >= 5);
      e_rise  = (j == 5);
      checks++;
      if ({in_clean, rise, fall, busy} !== {e_clean, e_rise, 1'b0, e_busy}) begin
        errors++;
        $display("FAIL reset_high_post k+%0d: got clean/rise/fall/busy=%b, expected %b", j,
                 {in_clean, rise, fall, busy}, {e_clean, e_rise, 1'b0, e_busy});
      end
    end
    raw_in = 1'b0;
    repeat (8) tick();
    checks++;
    if ({in_clean, busy} !== 2'b00) begin
      errors++;
      $display("FAIL reset_high_settle: got clean/busy=%b, expected 00", {in_clean, busy});
    end
  endtask

  // DB_CYCLES=1: raw toggles every 3 cycles; clean follows each sample 2 edges later.
  task automatic test_min_db;
    logic a0, a1, a2, e_clean, e_rise, e_fall, prev;
    int   pulses;
    a0 = 1'b0; a1 = 1'b0; a2 = 1'b0; prev = 1'b0; pulses = 0;
    for (int i = 0; i < 24; i++) begin
      if (i % 3 == 0) raw1 = ~raw1;
      tick();
      a2 = a1; a1 = a0; a0 = raw1;
      e_clean = a2;
      e_rise  = e_clean & ~prev;
      e_fall  = ~e_clean & prev;
      prev    = e_clean;
      if (e_rise || e_fall) pulses++;
      checks++;
      if ({clean1, rise1, fall1, busy1} !== {e_clean, e_rise, e_fall, 1'b0}) begin
        errors++;
        $display("FAIL min_db t%0d: got clean/rise/fall/busy=%b, expected %b", i,
                 {clean1, rise1, fall1, busy1}, {e_clean, e_rise, e_fall, 1'b0});
      end
    end
    checks++;
    if (pulses != 8) begin
      errors++;
      $display("FAIL min_db_pulses: got %0d transitions in model window, expected 8", pulses);
    end
  endtask

  initial begin
    Reset = 1'b1; rst1 = 1'b1; raw_in = 1'b0; raw1 = 1'b0;
    test_reset();
    test_clean_rise();
    test_clean_fall();
    test_glitch();
    repeat (4) tick();
    test_reset_mid_qual();
    test_reset_in_high();
    test_min_db();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/in_debouncer.md
IN_DEBOUNCER -- requirements
Module: in_debouncer

Interface
REQ-001 The block SHALL expose parameter DB_CYCLES, default 4, the number of consecutive synchronized cycles a new level must hold before it is accepted (legal range 1..255).
REQ-002 The block SHALL expose parameter CNT_W, default 8, the stability counter width, which must satisfy 2^CNT_W > DB_CYCLES.
REQ-003 Clk  input  1  rising-edge system clock.
REQ-004 Reset  input  1  synchronous, active-high reset, sampled on Clk.
REQ-005 raw_in  input  1  asynchronous, bouncy serial input bit.
REQ-006 in_clean  output  1  debounced, synchronized level that directly drives the "in" input of the downstream sequence-detector FSM.
REQ-007 rise  output  1  one-cycle pulse marking the cycle in which in_clean first reads 1.
REQ-008 fall  output  1  one-cycle pulse marking the cycle in which in_clean first reads 0.
REQ-009 busy  output  1  high while a candidate level change is being qualified.

Function
REQ-010 raw_in SHALL pass through a two-flop synchronizer (s1, then s2) before any other logic uses it.
REQ-011 The FSM SHALL have four states: LOW, WAIT_H, HIGH, and WAIT_L.
REQ-012 In LOW or HIGH, at any edge where s2 differs from in_clean, the FSM SHALL move to WAIT_H or WAIT_L respectively and set cnt to 1; if DB_CYCLES==1, it SHALL instead toggle immediately (see REQ-014).
REQ-013 In WAIT_H or WAIT_L, at any edge where s2 differs from in_clean and cnt < DB_CYCLES-1, the FSM SHALL increment cnt.
REQ-014 At any edge where s2 differs from in_clean and cnt == DB_CYCLES-1, the FSM SHALL toggle in_clean, move to HIGH or LOW, and clear cnt.
REQ-015 In WAIT_H or WAIT_L, at any edge where s2 equals in_clean (a glitch), the FSM SHALL return to the prior stable state, clear cnt, and leave in_clean unchanged with no pulse.
REQ-016 Latency: if edge k is the first edge sampling raw_in at the new level and the level is held, in_clean SHALL change at edge k+1+DB_CYCLES.
REQ-017 rise and fall SHALL be registered and SHALL be high only during the first cycle of the new in_clean level, never both in the same cycle.
REQ-018 busy SHALL be 1 exactly when the state is WAIT_H or WAIT_L.
REQ-019 cnt SHALL never exceed DB_CYCLES-1 and SHALL never wrap.
REQ-020 A level that reverses during qualification SHALL restart qualification from cnt=0 with no partial credit.

Reset
REQ-021 While Reset is 1, the block SHALL force s1, s2, cnt, in_clean, rise, fall, and busy to 0 and the state to LOW.
REQ-022 Reset asserted mid-qualification SHALL abandon the qualification; after release, a still-high raw_in SHALL require a full fresh qualification.
REQ-023 Reset asserted while in HIGH SHALL drop in_clean to 0 without a fall pulse.

Structure
REQ-024 Package in_debouncer_pkg SHALL hold the 2-bit state encodings LOW=0, WAIT_H=1, HIGH=2, and WAIT_L=3, plus the default DB_CYCLES and CNT_W values.
REQ-025 The synchronizer SHALL be a separate sub-module, sync_2ff (ports Clk, Reset, d, q), instantiated once.
REQ-026 The remaining FSM, counter, and pulse logic SHALL be in a single module.

Verification
REQ-027 The bench SHALL cover reset: DB_CYCLES=4, Reset=1 for 3 cycles with raw_in=1 -> in_clean=rise=fall=busy=0 throughout.
REQ-028 The bench SHALL cover a clean rise: raw_in 0->1 first sampled at edge k and held -> busy=1 after edges k+2..k+4, in_clean=1 from edge k+5, rise=1 for exactly that one cycle.
REQ-029 The bench SHALL cover a glitch: raw_in high for 2 cycles then low -> in_clean stays 0, rise never asserts, busy returns to 0.
REQ-030 The bench SHALL cover a clean fall: from HIGH, raw_in held low from edge k -> in_clean=0 from edge k+5, fall=1 for one cycle, rise stays 0.
REQ-031 The bench SHALL cover reset mid-qualification: Reset pulsed at edge k+3 during WAIT_H with raw_in held at 1 -> no rise before release, then in_clean=1 exactly DB_CYCLES+1 edges after the first post-release sampling edge.
REQ-032 The bench SHALL cover the minimum debounce setting: DB_CYCLES=1, raw_in toggling every 3 cycles -> every transition passes with 2-edge latency and alternating rise/fall pulses.
